// File: rtl/text_console_writer.sv
// ASCII byte stream to character-RAM writer with cursor, control codes and circular-offset scrolling.
// Cell write is registered 1 cycle after accept; in_ready drops while a line or screen clear is streaming.
module text_console_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int TAB_W  = 4,
  parameter int SCROLL = 1,
  parameter int AW     = $clog2(COLS*ROWS),
  parameter int CW     = $clog2(COLS),
  parameter int RW     = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [5:0]    wr_data,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic [RW-1:0] top_row,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_CLA  = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(COLS*ROWS - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [CW:0]   COLS_X    = (CW+1)'(COLS);
  localparam logic [CW:0]   TAB_X     = (CW+1)'(TAB_W);
  localparam logic [CW:0]   TAB_MASK  = (CW+1)'(TAB_W - 1);
  localparam logic [RW:0]   ROWS_X    = (RW+1)'(ROWS);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] top_q, top_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [5:0]    wr_data_q, wr_data_d;

  logic          adv;
  logic [RW:0]   psum;
  logic [RW-1:0] phys_row;
  logic [AW-1:0] cell_addr;
  logic [AW-1:0] clr_addr;
  logic [CW:0]   tab_nxt;

  // Physical row without assuming ROWS is a power of two: the sum is < 2*ROWS.
  always_comb begin
    psum      = {1'b0, top_q} + {1'b0, row_q};
    phys_row  = (psum >= ROWS_X) ? RW'(psum - ROWS_X) : psum[RW-1:0];
    cell_addr = AW'(phys_row) * COLS_A + AW'(col_q);
    clr_addr  = AW'(clr_row_q) * COLS_A + cnt_q;
    tab_nxt   = ({1'b0, col_q} & ~TAB_MASK) + TAB_X;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_row_d = clr_row_q;
    col_d     = col_q;
    row_d     = row_q;
    top_d     = top_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    adv       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && !in_data[7]) begin
          if (in_data[6:5] != 2'b00) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr;
            wr_data_d = {in_data[6], in_data[4:0]};
            if (col_q == LAST_COL) begin
              col_d = '0;
              adv   = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (in_data[4:0])
              5'h0A: begin
                col_d = '0;
                adv   = 1'b1;
              end
              5'h0D: col_d = '0;
              5'h08: if (col_q != '0) col_d = col_q - 1'b1;
              5'h09: begin
                if (tab_nxt >= COLS_X) begin
                  col_d = '0;
                  adv   = 1'b1;
                end else begin
                  col_d = tab_nxt[CW-1:0];
                end
              end
              5'h0C: begin
                col_d   = '0;
                row_d   = '0;
                top_d   = '0;
                cnt_d   = '0;
                state_d = CLR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr;
        wr_data_d = 6'h00;
        if (cnt_q == LAST_CLA) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      CLR_SCREEN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = 6'h00;
        if (cnt_q == LAST_CELL) state_d = IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = CLR_SCREEN;
    endcase

    // The line to blank is always the old top row: after a scroll it becomes the bottom line.
    if (adv) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + 1'b1;
      end else begin
        state_d   = CLR_LINE;
        cnt_d     = '0;
        clr_row_d = top_q;
        if (SCROLL != 0) top_d = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
        else             row_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLR_SCREEN;
      cnt_q     <= '0;
      clr_row_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      top_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_row_q <= clr_row_d;
      col_q     <= col_d;
      row_q     <= row_d;
      top_q     <= top_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign top_row    = top_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed vector table, hand sequences, and a randomized run against a reference model.
module tb_text_console_writer;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int TAB_W = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, in_valid0, in_ready0, wr_en0, busy0;
  logic [7:0] in_data0;
  logic [3:0] wr_addr0;
  logic [5:0] wr_data0;
  logic [1:0] col0, row0, top0;

  logic       rst1, in_valid1, in_ready1, wr_en1, busy1;
  logic [7:0] in_data1;
  logic [3:0] wr_addr1;
  logic [5:0] wr_data1;
  logic [1:0] col1, row1, top1;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W), .SCROLL(1)) u0 (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .cursor_col(col0),
    .cursor_row(row0), .top_row(top0), .busy(busy0));

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W), .SCROLL(0)) u1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .cursor_col(col1),
    .cursor_row(row1), .top_row(top1), .busy(busy1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         wr;
    int         addr;
    int         data;
    int         col;
    int         row;
    int         top;
    int         ncl;
    int         base;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  // Reference model state (SCROLL=1 instance only)
  int m_col, m_row, m_top, m_busy, m_clr;
  int exp_wr, exp_addr, exp_data;

  task automatic model_accept(input int b);
    int adv;
    adv = 0;
    if (b >= 'h80) return;
    if (b >= 'h20) begin
      exp_wr   = 1;
      exp_addr = ((m_top + m_row) % ROWS) * COLS + m_col;
      exp_data = (b < 'h60) ? b - 'h20 : b - 'h40;
      m_col++;
      if (m_col == COLS) begin m_col = 0; adv = 1; end
    end else if (b == 'h0A) begin
      m_col = 0; adv = 1;
    end else if (b == 'h0D) begin
      m_col = 0;
    end else if (b == 'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 'h09) begin
      m_col = (m_col / TAB_W + 1) * TAB_W;
      if (m_col >= COLS) begin m_col = 0; adv = 1; end
    end else if (b == 'h0C) begin
      m_col = 0; m_row = 0; m_top = 0; m_busy = COLS * ROWS; m_clr = 0;
    end
    if (adv != 0) begin
      if (m_row < ROWS - 1) m_row++;
      else begin
        m_clr  = m_top * COLS;
        m_busy = COLS;
        m_top  = (m_top + 1) % ROWS;
      end
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 15);
    if (r < 8 || r == 15) return 8'($urandom_range('h20, 'h7F));
    case (r)
      8:  return 8'h0A;
      9:  return 8'h0D;
      10: return 8'h08;
      11: return 8'h09;
      12: return ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h41;
      13: return 8'($urandom_range(0, 'h1F));
      default: return 8'($urandom_range('h80, 'hFF));
    endcase
  endfunction

  task automatic send1(input logic [7:0] b);
    in_data1  = b;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h0D, 1'b0, 0,  0,     0, 0, 0, 0,  0};
    tbl[1]  = '{8'h08, 1'b0, 0,  0,     0, 0, 0, 0,  0};
    tbl[2]  = '{8'h09, 1'b0, 0,  0,     2, 0, 0, 0,  0};
    tbl[3]  = '{8'h09, 1'b0, 0,  0,     0, 1, 0, 0,  0};
    tbl[4]  = '{8'h07, 1'b0, 0,  0,     0, 1, 0, 0,  0};
    tbl[5]  = '{8'h9A, 1'b0, 0,  0,     0, 1, 0, 0,  0};
    tbl[6]  = '{8'h30, 1'b1, 4,  'h10,  1, 1, 0, 0,  0};
    tbl[7]  = '{8'h0A, 1'b0, 0,  0,     0, 2, 0, 0,  0};
    tbl[8]  = '{8'h57, 1'b1, 8,  'h37,  1, 2, 0, 0,  0};
    tbl[9]  = '{8'h58, 1'b1, 9,  'h38,  2, 2, 0, 0,  0};
    tbl[10] = '{8'h59, 1'b1, 10, 'h39,  3, 2, 0, 0,  0};
    tbl[11] = '{8'h5A, 1'b1, 11, 'h3A,  0, 2, 1, 4,  0};
    tbl[12] = '{8'h21, 1'b1, 0,  'h01,  1, 2, 1, 0,  0};
    tbl[13] = '{8'h08, 1'b0, 0,  0,     0, 2, 1, 0,  0};
    tbl[14] = '{8'h0A, 1'b0, 0,  0,     0, 2, 2, 4,  4};
    tbl[15] = '{8'h7E, 1'b1, 4,  'h3E,  1, 2, 2, 0,  0};
    tbl[16] = '{8'h09, 1'b0, 0,  0,     2, 2, 2, 0,  0};
    tbl[17] = '{8'h20, 1'b1, 6,  'h00,  3, 2, 2, 0,  0};
    tbl[18] = '{8'h7F, 1'b1, 7,  'h3F,  0, 2, 0, 4,  8};
    tbl[19] = '{8'h0C, 1'b0, 0,  0,     0, 0, 0, 12, 0};
    tbl[20] = '{8'h42, 1'b1, 0,  'h22,  1, 0, 0, 0,  0};

    rst0 = 1'b1; in_valid0 = 1'b0; in_data0 = 8'h00;
    rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wr_en", wr_en0, 0);
    chk("rst_wr_addr", wr_addr0, 0);
    chk("rst_wr_data", wr_data0, 0);
    chk("rst_col", col0, 0);
    chk("rst_row", row0, 0);
    chk("rst_top", top0, 0);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_busy", busy0, 1);

    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("post_rst_wr_en", wr_en0, 0);
    chk("post_rst_in_ready", in_ready0, 0);
    for (int k = 1; k <= COLS * ROWS; k++) begin
      @(negedge clk);
      chk("scr_wr_en", wr_en0, 1);
      chk("scr_addr", wr_addr0, k - 1);
      chk("scr_data", wr_data0, 0);
      chk("scr_in_ready", in_ready0, (k == COLS * ROWS) ? 1 : 0);
    end
    chk("scr_col", col0, 0);
    chk("scr_row", row0, 0);

    // Back-to-back bytes, one per cycle
    in_data0 = 8'h41; in_valid0 = 1'b1;
    @(negedge clk);
    chk("b2b_A_en", wr_en0, 1); chk("b2b_A_addr", wr_addr0, 0); chk("b2b_A_data", wr_data0, 'h21);
    chk("b2b_A_rdy", in_ready0, 1);
    in_data0 = 8'h61;
    @(negedge clk);
    chk("b2b_a_en", wr_en0, 1); chk("b2b_a_addr", wr_addr0, 1); chk("b2b_a_data", wr_data0, 'h21);
    chk("b2b_a_rdy", in_ready0, 1);
    in_data0 = 8'h7A;
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("b2b_z_en", wr_en0, 1); chk("b2b_z_addr", wr_addr0, 2); chk("b2b_z_data", wr_data0, 'h3A);
    chk("b2b_z_rdy", in_ready0, 1);
    chk("b2b_col", col0, 3);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      in_data0 = tbl[i].b; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      chk($sformatf("v%0d_wr_en", i), wr_en0, int'(tbl[i].wr));
      if (tbl[i].wr) begin
        chk($sformatf("v%0d_addr", i), wr_addr0, tbl[i].addr);
        chk($sformatf("v%0d_data", i), wr_data0, tbl[i].data);
      end
      chk($sformatf("v%0d_col", i), col0, tbl[i].col);
      chk($sformatf("v%0d_row", i), row0, tbl[i].row);
      chk($sformatf("v%0d_top", i), top0, tbl[i].top);
      chk($sformatf("v%0d_in_ready", i), in_ready0, (tbl[i].ncl == 0) ? 1 : 0);
      for (int k = 0; k < tbl[i].ncl; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d_clr_en", i), wr_en0, 1);
        chk($sformatf("v%0d_clr_addr", i), wr_addr0, tbl[i].base + k);
        chk($sformatf("v%0d_clr_data", i), wr_data0, 0);
        chk($sformatf("v%0d_clr_rdy", i), in_ready0, (k == tbl[i].ncl - 1) ? 1 : 0);
      end
    end
    @(negedge clk);
    chk("tbl_idle_wr_en", wr_en0, 0);

    // SCROLL=0: LF x3 wraps to row 0 with a line clear of physical row 0
    send1(8'h0A); chk("s0_lf1_row", row1, 1); chk("s0_lf1_en", wr_en1, 0);
    send1(8'h0A); chk("s0_lf2_row", row1, 2);
    send1(8'h0A); chk("s0_lf3_row", row1, 0); chk("s0_lf3_top", top1, 0);
    chk("s0_lf3_rdy", in_ready1, 0);
    for (int k = 0; k < COLS; k++) begin
      @(negedge clk);
      chk("s0_clr_en", wr_en1, 1);
      chk("s0_clr_addr", wr_addr1, k);
      chk("s0_clr_rdy", in_ready1, (k == COLS - 1) ? 1 : 0);
    end
    send1(8'h0A); send1(8'h0A);
    send1(8'h0A);
    @(negedge clk);
    @(negedge clk);
    chk("s0_midclr_addr", wr_addr1, 1);
    rst1 = 1'b1;
    #1;
    chk("s0_abort_en", wr_en1, 0);
    chk("s0_abort_addr", wr_addr1, 0);
    chk("s0_abort_row", row1, 0);
    chk("s0_abort_top", top1, 0);
    chk("s0_abort_rdy", in_ready1, 0);
    @(negedge clk);
    rst1 = 1'b0;
    for (int k = 1; k <= COLS * ROWS; k++) begin
      @(negedge clk);
      chk("s0_rescr_en", wr_en1, 1);
      chk("s0_rescr_addr", wr_addr1, k - 1);
      chk("s0_rescr_rdy", in_ready1, (k == COLS * ROWS) ? 1 : 0);
    end

    // Randomized run against the reference model
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    m_col = 0; m_row = 0; m_top = 0; m_busy = COLS * ROWS; m_clr = 0;
    in_valid0 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      exp_wr = 0; exp_addr = 0; exp_data = 0;
      if (m_busy > 0) begin
        exp_wr = 1; exp_addr = m_clr; exp_data = 0;
        m_clr++; m_busy--;
      end else if (in_valid0) begin
        model_accept(int'(in_data0));
      end
      @(negedge clk);
      chk("rnd_wr_en", wr_en0, exp_wr);
      if (exp_wr != 0) begin
        chk("rnd_addr", wr_addr0, exp_addr);
        chk("rnd_data", wr_data0, exp_data);
      end
      chk("rnd_in_ready", in_ready0, (m_busy == 0) ? 1 : 0);
      chk("rnd_col", col0, m_col);
      chk("rnd_row", row0, m_row);
      chk("rnd_top", top0, m_top);
      in_valid0 = ($urandom_range(0, 3) != 0);
      in_data0  = rand_byte();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
Sequential successor to the combinational ASCII-to-font mapper. It accepts an ASCII byte stream over a valid/ready handshake and maps each printable byte to its 6-bit font index. It tracks a cursor, interprets control codes, and writes cells into an external COLS×ROWS character RAM. Scrolling uses a circular top-row offset that the display scanner reads, not a memory copy.

Parameters:
COLS, 40, characters per line (≥2)
ROWS, 30, lines per screen (≥2)
TAB_W, 4, tab stop spacing (power of 2, ≤COLS)
SCROLL, 1, 1 = scroll at bottom line; 0 = wrap cursor to row 0
AW, $clog2(COLS*ROWS), character RAM address width
CW, $clog2(COLS), column width
RW, $clog2(ROWS), row width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_data  in  8  ASCII byte
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a byte; high only in IDLE
wr_en  out  1  character RAM write strobe, registered
wr_addr  out  AW  character RAM address = phys_row*COLS + col, registered
wr_data  out  6  font index, registered
cursor_col  out  CW  logical cursor column
cursor_row  out  RW  logical cursor row (0 = top of visible screen)
top_row  out  RW  physical RAM row shown at the top of the screen
busy  out  1  clear in progress (= !in_ready)

Behaviour:
- One clock, clk; rst is asynchronous and active-high.
- Font map: font = {c[6], c[4:0]}.
  - Printable iff c[7]=0 and c[6:5]≠00.
  - Bytes ≥0x80 are consumed and ignored.
  - Blank cell = 6'h00, the font index of 0x20.
- phys_row = (top_row + cursor_row) mod ROWS. No power-of-2 assumption.
- Reset (async, while rst=1):
  - cursor 0,0; top_row 0; wr_en 0; wr_addr 0; wr_data 0.
  - State = CLR_SCREEN with counter 0.
- States: IDLE, CLR_LINE, CLR_SCREEN.
- Handshake:
  - Byte is accepted on a rising edge with in_valid & in_ready.
  - in_ready is combinational = (state==IDLE).
  - One byte per cycle is sustained while no clear is triggered.
- Printable accept:
  - Next cycle: wr_en=1, wr_addr=cell at cursor, wr_data=font.
  - Write latency is 1 cycle.
  - Then col+1. If col was COLS-1: col=0 and row advance.
- Row advance:
  - If row<ROWS-1: row+1, no clear.
  - Else, SCROLL=1: row stays ROWS-1; top_row=(top_row+1) mod ROWS; enter CLR_LINE on the physical row that becomes the bottom line (old top_row).
  - Else, SCROLL=0: row=0; enter CLR_LINE on physical row top_row.
- Controls (consumed, no char write):
  - 0x0A LF: col=0, row advance.
  - 0x0D CR: col=0.
  - 0x08 BS: col-1 if col>0, otherwise no change. No erase.
  - 0x09 TAB: col = next multiple of TAB_W. If that is ≥COLS: col=0 and row advance.
  - 0x0C FF: cursor 0,0; top_row 0; enter CLR_SCREEN.
  - All other bytes <0x20 are ignored.
- CLR_LINE:
  - Exactly COLS consecutive cycles of wr_en=1, wr_data=0, columns 0..COLS-1 of the target physical row.
  - Returns to IDLE on the edge after the last write's address is issued.
  - If a printable char triggered the wrap, its write precedes the first clear write with no gap.
- CLR_SCREEN:
  - COLS*ROWS writes of 0 to addresses 0..COLS*ROWS-1, ascending, one per cycle.
  - Then IDLE.
- wr_en is 0 in every cycle not listed above.
- Bytes presented while busy are held by the source and not lost.
- in_valid is ignored when in_ready=0.
- Reset mid-clear aborts the clear immediately and restarts the full screen clear.

Test Plan:
Use COLS=4, ROWS=3, TAB_W=2, SCROLL=1 unless stated.
1. Release reset with in_valid=0 -> 12 cycles of wr_en, addr 0..11, data 0; in_ready low during them, then high; cursor 0,0.
2. Send "A","a","z" back-to-back -> writes (addr0, 0x21), (addr1, 0x21), (addr2, 0x3A), one per cycle; in_ready stays 1; cursor col=3.
3. Send "WXYZ" at row 2 with top_row 0 -> Z written at addr 11, then 4 clear writes at addr 0..3; top_row=1; cursor 2,0; in_ready low exactly 4 cycles.
4. Send CR, BS at col 0, TAB, TAB, 0x07, 0x9A -> col 0, 0, 2, then wrap to next row col 0; no writes for 0x07 or 0x9A.
5. Send FF after scrolling -> top_row=0, cursor 0,0, 12 clear writes; then "B" writes addr 0, data 0x22.
6. Set SCROLL=0 and send LF×3 -> row 0,1,2, then wraps to 0 with a line clear of addr 0..3. Separately, assert rst during that clear -> outputs reset at once and a 12-write screen clear restarts.
